switches_mgmt: RTL and testbench

- Input-side counterpart of the LED output path: conditions 8 raw board switches/buttons into clean, clock-synchronous levels and event pulses.
- Per bit: 2-flop synchronizer, then a debounce counter, then edge detection.
- Also provides a sticky "changed" flag with an acknowledge handshake, so a slow consumer (display or FSM logic) never misses an update.
- Sits between the top-level pin inputs and the core logic; its `out` bus can drive the LED output path directly.

---
 rtl/switches_mgmt_pkg.sv | 22 ++
 rtl/switches_mgmt_debounce_bit.sv | 74 +++++++
 rtl/switches_mgmt.sv | 56 +++++
 tb/tb_switches_mgmt.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/switches_mgmt_pkg.sv
// Constants shared by the switch-conditioning path: the default debounce
// interval (10 ms of the 50 MHz board clock) and a constant-evaluable clog2.
package switches_mgmt_pkg;

    localparam int BOARD_CLK_HZ     = 50_000_000;
    localparam int DEBOUNCE_MS      = 10;
    localparam int DEBOUNCE_DEFAULT = (BOARD_CLK_HZ / 1000) * DEBOUNCE_MS;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = (value > 1) ? value - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/switches_mgmt_debounce_bit.sv
// One conditioned input bit: 2-flop synchronizer, debounce counter,
// debounced level and registered rise/fall pulses.
module debounce_bit
    import switches_mgmt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic flip_o
);

    localparam int              CNT_W   = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Plain flop pair, nothing in between, so metastability gets a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            level_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    // Next-cycle flip, so the shared changed flag sets together with the pulse.
    assign flip_o  = rise_d | fall_d;

endmodule

// File: rtl/switches_mgmt.sv
// Conditions WIDTH raw switches into debounced levels, edge pulses and a
// sticky changed flag that a slow consumer clears with ack.
module switches_mgmt
    import switches_mgmt_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    input  logic             ack
);

    logic [WIDTH-1:0] flip;
    logic             changed_q, changed_d;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (in[g]),
            .level_o(out[g]),
            .rise_o (rise[g]),
            .fall_o (fall[g]),
            .flip_o (flip[g])
        );
    end

    // A flip in the same cycle as ack wins, so no event is lost.
    always_comb begin
        changed_d = changed_q;
        if (|flip) begin
            changed_d = 1'b1;
        end else if (ack) begin
            changed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_switches_mgmt.sv
// Randomized and directed bench for switches_mgmt with a sample-window model.
module tb_switches_mgmt;

    localparam int DC = 4;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in  = '0;
    logic         ack = 1'b0;
    logic [W-1:0] out, rise, fall;
    logic         changed;

    int n_pass  = 0;
    int n_total = 0;

    switches_mgmt #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .out    (out),
        .rise   (rise),
        .fall   (fall),
        .changed(changed),
        .ack    (ack)
    );

    always #5 clk = ~clk;

    // Model: out flips once the last DC synchronized samples all disagree with it.
    logic [W-1:0]  m_s1 = '0, m_s2 = '0;
    logic [W-1:0]  m_out = '0, m_rise = '0, m_fall = '0;
    logic          m_changed = 1'b0;
    logic [DC-1:0] win [W];

    initial for (int i = 0; i < W; i++) win[i] = '0;

    always @(posedge clk or posedge rst) begin
        logic any;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
            m_changed = 1'b0;
            for (int i = 0; i < W; i++) win[i] = '0;
        end else begin
            any = 1'b0;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                win[i] = {win[i][DC-2:0], m_s2[i]};
                if (win[i] == {DC{~m_out[i]}}) begin
                    m_out[i] = ~m_out[i];
                    if (m_out[i]) m_rise[i] = 1'b1;
                    else          m_fall[i] = 1'b1;
                    win[i] = {DC{m_out[i]}};
                    any = 1'b1;
                end
            end
            if (any)      m_changed = 1'b1;
            else if (ack) m_changed = 1'b0;
            m_s2 = m_s1;
            m_s1 = in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("out",     32'(out),     32'(m_out));
        check("rise",    32'(rise),    32'(m_rise));
        check("fall",    32'(fall),    32'(m_fall));
        check("changed", 32'(changed), 32'(m_changed));
        check("rise_fall_overlap", 32'(rise & fall), 32'h0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input logic [W-1:0] mask, input logic [W-1:0] val, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((out & mask) != val) && n < 50);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    initial begin
        int n;
        int rise3;
        logic bounce [5];
        bounce[0] = 1'b1; bounce[1] = 1'b0; bounce[2] = 1'b1; bounce[3] = 1'b1; bounce[4] = 1'b0;

        repeat (3) step();
        rst = 1'b0;

        repeat (20) step();
        check("idle_out", 32'(out), 32'h0);
        check("idle_changed", 32'(changed), 32'h0);

        in = 8'h01;
        wait_out(8'hFF, 8'h01, n);
        check("step_latency", n, 6);
        check("step_rise", 32'(rise), 32'h01);
        step();
        check("step_rise_gone", 32'(rise), 32'h00);
        check("step_changed", 32'(changed), 32'h1);
        repeat (3) step();
        check("changed_sticky", 32'(changed), 32'h1);
        do_ack();
        check("ack_clears", 32'(changed), 32'h0);

        rise3 = 0;
        for (int k = 0; k < 5; k++) begin
            in[3] = bounce[k];
            step();
            if (rise[3]) rise3++;
            check("bounce_out3_low", 32'(out[3]), 32'h0);
        end
        in[3] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            if (rise[3]) rise3++;
        end while (!out[3] && n < 50);
        check("bounce_latency", n, 6);
        repeat (4) begin
            step();
            if (rise[3]) rise3++;
        end
        check("bounce_rise_count", rise3, 1);
        do_ack();

        in[7] = 1'b1;
        wait_out(8'h80, 8'h80, n);
        do_ack();
        check("ack_clear2", 32'(changed), 32'h0);
        in[7] = 1'b0;
        repeat (5) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("fall7_pulse", 32'(fall), 32'h80);
        check("ack_vs_flip", 32'(changed), 32'h1);
        do_ack();
        check("ack_clear3", 32'(changed), 32'h0);

        in = 8'h00;
        repeat (10) step();
        do_ack();
        in = 8'hFF;
        wait_out(8'hFF, 8'hFF, n);
        check("ff_latency", n, 6);
        check("ff_rise", 32'(rise), 32'hFF);
        check("ff_nofall", 32'(fall), 32'h00);
        repeat (4) step();
        in = 8'h00;
        wait_out(8'hFF, 8'h00, n);
        check("00_latency", n, 6);
        check("00_fall", 32'(fall), 32'hFF);
        check("00_norise", 32'(rise), 32'h00);
        repeat (4) step();
        do_ack();

        in = 8'hA5;
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("rst_async_out", 32'(out), 32'h0);
        repeat (3) step();
        check("rst_hold_out", 32'(out), 32'h0);
        rst = 1'b0;
        wait_out(8'hFF, 8'hA5, n);
        check("rst_release_latency", n, 6);
        check("rst_release_rise", 32'(rise), 32'hA5);
        check("rst_release_changed", 32'(changed), 32'h1);

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0) in = W'($urandom);
            else                           in[$urandom_range(0, W-1)] ^= 1'b1;
            repeat ($urandom_range(1, 7)) begin
                ack = ($urandom_range(0, 3) == 0);
                step();
            end
            ack = 1'b0;
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                rst = 1'b0;
            end
        end
        repeat (12) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
